// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_if
//  Description : Data-memory valid/ready bus between the load/store unit
//                (master) and the memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_we,
        output mem_wstrb,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_we,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. Uses the ALU result as effective address,
//                runs one data-memory transaction over a valid/ready bus and
//                returns sign/zero-extended load data. Stalls the core while
//                a transaction is outstanding; aborts on bus timeout.
//                Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses
//                are not issued and complete immediately with err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        req,
    input  wire logic        we,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic      [31:0] rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    lsu_if.master            mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_issue;
    logic                 w_trap;
    logic                 w_complete;
    logic                 w_timeout;
    logic                 w_expire;
    logic                 w_misalign;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [1:0]           r_lane;
    logic [3:0]           w_wstrb;
    logic [31:0]          w_wdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfword on an odd byte, or any word-class access not on a word boundary.
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        (funct3[1] && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // The expiry cycle is the one whose missing ready would bring the count to TIMEOUT.
    assign w_expire = (TIMEOUT != 0) && (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

    // Next state, transaction events and the core stall.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_trap       = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = req;
                if (req) begin
                    if (w_misalign) begin
                        w_trap       = 1'b1;
                        w_state_next = RESP;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = BUS;
                    end
                end
            end
            BUS: begin
                busy = 1'b1;
                // A ready arriving on the expiry cycle still completes normally.
                if (mem.mem_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = RESP;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Store byte enables and lane-replicated store data; loads drive no strobes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = wdata;
            end
        endcase
        if (!we) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load lane selection and sign/zero extension from the latched access.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem.mem_rdata[7:0];
            2'd1:    w_byte = mem.mem_rdata[15:8];
            2'd2:    w_byte = mem.mem_rdata[23:16];
            default: w_byte = mem.mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus request registers and timeout counter; outputs are frozen while in BUS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_we    <= 1'b0;
            mem.mem_wstrb <= 4'd0;
            mem.mem_wdata <= 32'd0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_lane        <= 2'd0;
        end else begin
            if ((r_state == IDLE) && req) begin
                r_we     <= we;
                r_funct3 <= funct3;
                r_lane   <= addr[1:0];
            end
            if (w_issue) begin
                mem.mem_valid <= 1'b1;
                mem.mem_addr  <= {addr[31:2], 2'b00};
                mem.mem_we    <= we;
                mem.mem_wstrb <= w_wstrb;
                mem.mem_wdata <= w_wdata;
                r_cnt         <= '0;
            end else if (r_state == BUS) begin
                if (w_complete || w_timeout) begin
                    mem.mem_valid <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + TIMEOUT_W'(1);
                end
            end
        end
    end

    // One-cycle completion/fault pulse with load result; stores and faults return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            done  <= w_complete || w_timeout || w_trap;
            err   <= w_timeout || w_trap;
            rdata <= (w_complete && !r_we) ? w_load : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu
//  Description : Directed self-checking bench for lsu (TIMEOUT=4 build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks;
    int n_errors;
    int n_busy;

    lsu_if mif ();

    lsu #(
        .TIMEOUT_W (8),
        .TIMEOUT   (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .mem    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in cycle N; returns 1 time unit into cycle N+1.
    task automatic start(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req    = 1'b1;
        we     = w;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        #1;
        check("busy_req", {31'd0, busy}, 32'd1);
        step();
        req = 1'b0;
    endtask

    // Give ready in the current BUS cycle and check the completion cycle and the one after.
    task automatic finish(input string tag, input logic [31:0] md, input logic [31:0] exp_rd);
        mif.mem_ready = 1'b1;
        mif.mem_rdata = md;
        step();
        mif.mem_ready = 1'b0;
        check({tag, "_done"},  {31'd0, done},          32'd1);
        check({tag, "_err"},   {31'd0, err},           32'd0);
        check({tag, "_rdata"}, rdata,                  exp_rd);
        check({tag, "_busy"},  {31'd0, busy},          32'd0);
        check({tag, "_vld"},   {31'd0, mif.mem_valid}, 32'd0);
        step();
        check({tag, "_done1"}, {31'd0, done},          32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        req           = 1'b0;
        we            = 1'b0;
        funct3        = 3'd0;
        addr          = 32'd0;
        wdata         = 32'd0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'd0;
        step();
        step();
        check("rst_valid", {31'd0, mif.mem_valid}, 32'd0);
        check("rst_done",  {31'd0, done},          32'd0);
        check("rst_err",   {31'd0, err},           32'd0);
        check("rst_rdata", rdata,                  32'd0);
        check("rst_addr",  mif.mem_addr,           32'd0);
        check("rst_wstrb", {28'd0, mif.mem_wstrb}, 32'd0);
        reset = 1'b0;
        step();

        // Reset while the bus request is outstanding.
        start(1'b0, 3'b010, 32'h0000_0044, 32'd0);
        check("mid_valid_pre", {31'd0, mif.mem_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_valid", {31'd0, mif.mem_valid}, 32'd0);
        check("mid_done",  {31'd0, done},          32'd0);
        check("mid_err",   {31'd0, err},           32'd0);
        check("mid_rdata", rdata,                  32'd0);
        check("mid_busy",  {31'd0, busy},          32'd0);
        check("mid_addr",  mif.mem_addr,           32'd0);
        step();
        reset = 1'b0;
        step();

        // LB / LBU on the top byte lane, zero-wait memory.
        start(1'b0, 3'b000, 32'h0000_0103, 32'd0);
        check("lb_valid", {31'd0, mif.mem_valid}, 32'd1);
        check("lb_addr",  mif.mem_addr,           32'h0000_0100);
        check("lb_wstrb", {28'd0, mif.mem_wstrb}, 32'd0);
        finish("lb", 32'h80FF_1234, 32'hFFFF_FF80);
        start(1'b0, 3'b100, 32'h0000_0103, 32'd0);
        finish("lbu", 32'h80FF_1234, 32'h0000_0080);

        // LH / LHU on the upper halfword.
        start(1'b0, 3'b001, 32'h0000_0102, 32'd0);
        finish("lh", 32'h80FF_1234, 32'hFFFF_80FF);
        start(1'b0, 3'b101, 32'h0000_0102, 32'd0);
        finish("lhu", 32'h80FF_1234, 32'h0000_80FF);

        // SH upper lane.
        start(1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
        check("sh_addr",  mif.mem_addr,           32'h0000_0200);
        check("sh_wstrb", {28'd0, mif.mem_wstrb}, 32'h0000_000C);
        check("sh_wdata", mif.mem_wdata,          32'hBEEF_BEEF);
        check("sh_we",    {31'd0, mif.mem_we},    32'd1);
        finish("sh", 32'h1234_5678, 32'd0);

        // SB lane 1 and SW.
        start(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5);
        check("sb_wstrb", {28'd0, mif.mem_wstrb}, 32'h0000_0002);
        check("sb_wdata", mif.mem_wdata,          32'hA5A5_A5A5);
        finish("sb", 32'd0, 32'd0);
        start(1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF);
        check("sw_wstrb", {28'd0, mif.mem_wstrb}, 32'h0000_000F);
        check("sw_wdata", mif.mem_wdata,          32'hDEAD_BEEF);
        finish("sw", 32'd0, 32'd0);

        // LW with ready low for the request cycle and two BUS cycles.
        n_busy = 1;
        start(1'b0, 3'b010, 32'h0000_0010, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("lw_wait_valid", {31'd0, mif.mem_valid}, 32'd1);
            check("lw_wait_addr",  mif.mem_addr,           32'h0000_0010);
            check("lw_wait_done",  {31'd0, done},          32'd0);
            if (busy) n_busy++;
            step();
        end
        check("lw_wait_valid3", {31'd0, mif.mem_valid}, 32'd1);
        if (busy) n_busy++;
        finish("lw_wait", 32'hCAFE_F00D, 32'hCAFE_F00D);
        check("lw_busy_cycles", n_busy, 32'd4);

        // Ready arrives exactly on the timeout-expiry cycle: ready wins.
        start(1'b0, 3'b011, 32'h0000_0020, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("edge_valid", {31'd0, mif.mem_valid}, 32'd1);
        finish("edge", 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // Ready never arrives: abort after four BUS cycles.
        start(1'b0, 3'b010, 32'h0000_0040, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("to_valid", {31'd0, mif.mem_valid}, 32'd1);
            step();
        end
        check("to_valid_drop", {31'd0, mif.mem_valid}, 32'd0);
        check("to_done",       {31'd0, done},          32'd1);
        check("to_err",        {31'd0, err},           32'd1);
        check("to_rdata",      rdata,                  32'd0);
        check("to_busy",       {31'd0, busy},          32'd0);
        step();
        check("to_done1", {31'd0, done}, 32'd0);
        check("to_err1",  {31'd0, err},  32'd0);

        // Misaligned LW.
        mif.mem_rdata = 32'h1122_3344;
        start(1'b0, 3'b010, 32'h0000_0002, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_valid", {31'd0, mif.mem_valid}, 32'd0);
        check("mis_done",  {31'd0, done},          32'd1);
        check("mis_err",   {31'd0, err},           32'd1);
        check("mis_rdata", rdata,                  32'd0);
        check("mis_busy",  {31'd0, busy},          32'd0);
        step();
        check("mis_done1", {31'd0, done}, 32'd0);
`else
        check("mis_valid", {31'd0, mif.mem_valid}, 32'd1);
        check("mis_addr",  mif.mem_addr,           32'h0000_0000);
        finish("mis", 32'h1122_3344, 32'h1122_3344);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
